// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between fetch, load and store.
// Stores finish in their grant cycle; reads wait MEM_LAT cycles for data.
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          ld_req,
  input  logic [AW-1:0] ld_addr,
  input  logic [2:0]    ld_op,
  output logic          ld_gnt,
  output logic          ld_rvalid,
  output logic [DW-1:0] ld_rdata,
  input  logic          st_req,
  input  logic [AW-1:0] st_addr,
  input  logic [2:0]    st_op,
  input  logic [DW-1:0] st_data,
  output logic          st_gnt,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [2:0]    mem_op,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  localparam logic [2:0] FETCH_OP = 3'b010;
  localparam logic [2:0] LAT      = 3'(MEM_LAT);
  localparam logic [3:0] SMAX     = 4'(STARVE_MAX);

  state_t        state_q;
  logic          owner_ld_q;
  logic [2:0]    lat_q;
  logic [3:0]    starve_q;
  logic          if_rvalid_q;
  logic          ld_rvalid_q;
  logic [DW-1:0] if_rdata_q;
  logic [DW-1:0] ld_rdata_q;

  logic g_if, g_ld, g_st, g_any, starved;

  assign starved = (starve_q == SMAX);

  // rst_n is active-high; grants are blocked while it is asserted
  always_comb begin
    g_if = 1'b0;
    g_ld = 1'b0;
    g_st = 1'b0;
    if (state_q == IDLE && !rst_n) begin
      if (starved && if_req) g_if = 1'b1;
      else if (st_req)       g_st = 1'b1;
      else if (ld_req)       g_ld = 1'b1;
      else if (if_req)       g_if = 1'b1;
    end
  end

  assign g_any  = g_if | g_ld | g_st;
  assign if_gnt = g_if;
  assign ld_gnt = g_ld;
  assign st_gnt = g_st;
  assign mem_en = g_any;
  assign mem_we = g_st;

  always_comb begin
    mem_addr = '0;
    mem_op   = '0;
    unique case (1'b1)
      g_st: begin
        mem_addr = st_addr;
        mem_op   = st_op;
      end
      g_ld: begin
        mem_addr = ld_addr;
        mem_op   = ld_op;
      end
      g_if: begin
        mem_addr = if_addr;
        mem_op   = FETCH_OP;
      end
      default: ;
    endcase
  end

  assign mem_wdata = g_any ? st_data : '0;

  assign busy      = (state_q == WAIT);
  assign if_rvalid = if_rvalid_q;
  assign ld_rvalid = ld_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign ld_rdata  = ld_rdata_q;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q     <= IDLE;
      owner_ld_q  <= 1'b0;
      lat_q       <= '0;
      starve_q    <= '0;
      if_rvalid_q <= 1'b0;
      ld_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      ld_rdata_q  <= '0;
    end else begin
      if_rvalid_q <= 1'b0;
      ld_rvalid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (g_if || g_ld) begin
            owner_ld_q <= g_ld;
            lat_q      <= LAT;
            state_q    <= WAIT;
          end
        end
        WAIT: begin
          lat_q <= lat_q - 3'd1;
          // last wait cycle: data is on mem_rdata now
          if (lat_q == 3'd1) begin
            state_q <= IDLE;
            if (owner_ld_q) begin
              ld_rdata_q  <= mem_rdata;
              ld_rvalid_q <= 1'b1;
            end else begin
              if_rdata_q  <= mem_rdata;
              if_rvalid_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
      if (if_req && !g_if)
        starve_q <= starved ? starve_q : starve_q + 4'd1;
      else
        starve_q <= '0;
    end
  end

endmodule
